// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial add/subtract sequencer for an external 1-bit ALU slice.
//
// Accepts two WIDTH-bit operands and an opcode over a valid/ready handshake.
// It streams the operands LSB-first into the slice, one bit per clock, and
// chains the slice's carry/borrow from bit to bit. It assembles the WIDTH-bit
// result and returns it over a second valid/ready handshake.
//
// Optional feature macro: ALU_SERIAL_ZERO_FLAG_EN. When it is defined, the
// block has a zero_flag output that is valid with out_valid.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake; op_a, op_b, op_cin, opcode latched on accept
//   out_valid / out_ready  response handshake; result, carry_out (and zero_flag)
//   alu_a, alu_b, alu_cin  per-bit drive to the slice (0 outside SHIFT)
//   alu_opcode             latched opcode to the slice (0 outside SHIFT)
//   alu_result             from the slice: [0] sum/diff bit, [1] carry/borrow

module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  output logic             zero_flag,
`endif
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_opcode,
  input  logic [1:0]       alu_result
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             nz_q, nz_d;  // OR of result bits shifted in so far
  logic             zf_q, zf_d;
`endif

  logic shifting;
  assign shifting = (state_q == StShift);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    nz_d    = nz_q;
    zf_d    = zf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          state_d = StShift;
          a_d     = op_a;
          b_d     = op_b;
          op_d    = opcode;
          carry_d = op_cin;
          cnt_d   = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          nz_d    = 1'b0;
          zf_d    = 1'b0;
`endif
        end
      end
      StShift: begin
        // Result fills from the MSB end so bit 0 lands in the LSB after WIDTH shifts.
        res_d   = {alu_result[0], res_q[WIDTH-1:1]};
        carry_d = alu_result[1];
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        nz_d    = nz_q | alu_result[0];
`endif
        if (cnt_q == LastBit) begin
          state_d = StDone;
          cout_d  = alu_result[1];
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          zf_d    = ~(nz_q | alu_result[0]);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered handshake flags: in_ready stays low through reset and rises on the
    // first edge spent in IDLE; out_valid rises one edge after DONE is entered.
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_q == StDone) && !(out_valid_q && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      nz_q        <= 1'b0;
      zf_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      nz_q        <= nz_d;
      zf_q        <= zf_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = res_q;
  assign carry_out  = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  assign zero_flag  = zf_q;
`endif

  // The slice is combinational, so it sees the current bit in the same cycle.
  assign alu_a      = shifting & a_q[0];
  assign alu_b      = shifting & b_q[0];
  assign alu_cin    = shifting & carry_q;
  assign alu_opcode = shifting ? op_q : 4'b0000;

endmodule
